draw_cmd_sender: RTL and testbench

- Initiator side of the render-unit command interface.
- Accepts one parallel draw command from the scene/command controller over a valid/ready handshake.
- Serializes the command into the byte packet the render unit consumes, driving ENB, STATUS, READING and RByte.
- Holds the transaction open until the render unit signals draw completion (FinishWrite) or a timeout expires, then releases the interface.

---
 rtl/draw_cmd_sender.sv | 146 ++++++++++++++
 tb/tb_draw_cmd_sender.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/draw_cmd_sender.sv
// Render-unit command initiator: accepts one parallel draw command, streams it
// as a 3/5/7-byte packet, then holds STATUS until FinishWrite or timeout.
module draw_cmd_sender #(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_W          = 16
) (
  input  logic       ACLK,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_type,
  input  logic [7:0] cmd_x0,
  input  logic [7:0] cmd_y0,
  input  logic [7:0] cmd_x1,
  input  logic [7:0] cmd_y1,
  input  logic [7:0] cmd_x2,
  input  logic [7:0] cmd_y2,
  output logic       ENB,
  output logic       STATUS,
  output logic       READING,
  output logic [7:0] RByte,
  input  logic       FinishRead,
  input  logic       FinishWrite,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       proto_err
);

  typedef enum logic [1:0] {IDLE, SEND, DRAW, RELEASE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [2:0]       k_q, k_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0][7:0]  pkt_q, pkt_d;
  logic             status_q, status_d;
  logic             reading_q, reading_d;
  logic [7:0]       rbyte_q, rbyte_d;
  logic             done_d, err_d, proto_d;
  logic             ready_d, busy_d;
  logic             cmd_ok;
  logic [2:0]       last_k;

  // Non-empty point count and a known shape code make a command sendable.
  assign cmd_ok = (cmd_type[1:0] != 2'd0) && (cmd_type[7:2] <= 6'd3);
  // Index of the final byte, N-1 = 2P.
  assign last_k = {pkt_q[0][1:0], 1'b0};

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    cnt_d     = cnt_q;
    pkt_d     = pkt_q;
    status_d  = status_q;
    reading_d = reading_q;
    rbyte_d   = rbyte_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    proto_d   = proto_err;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          pkt_d   = {cmd_y2, cmd_x2, cmd_y1, cmd_x1, cmd_y0, cmd_x0, cmd_type};
          proto_d = 1'b0;
          if (cmd_ok) begin
            state_d   = SEND;
            k_d       = 3'd0;
            status_d  = 1'b1;
            reading_d = 1'b1;
            rbyte_d   = cmd_type;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (FinishRead && (k_q != last_k)) proto_d = 1'b1;
        if (k_q == last_k) begin
          state_d   = DRAW;
          reading_d = 1'b0;
          rbyte_d   = 8'd0;
          cnt_d     = '0;
        end else begin
          k_d     = k_q + 3'd1;
          rbyte_d = pkt_q[k_q + 3'd1];
        end
      end
      DRAW: begin
        // FinishWrite takes priority over a simultaneous expiry.
        if (FinishWrite) begin
          state_d  = RELEASE;
          status_d = 1'b0;
          done_d   = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = RELEASE;
          status_d = 1'b0;
          err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge ACLK or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      k_q       <= 3'd0;
      cnt_q     <= '0;
      pkt_q     <= '0;
      status_q  <= 1'b0;
      reading_q <= 1'b0;
      rbyte_q   <= 8'd0;
      done      <= 1'b0;
      err       <= 1'b0;
      proto_err <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      cnt_q     <= cnt_d;
      pkt_q     <= pkt_d;
      status_q  <= status_d;
      reading_q <= reading_d;
      rbyte_q   <= rbyte_d;
      done      <= done_d;
      err       <= err_d;
      proto_err <= proto_d;
      cmd_ready <= ready_d;
      busy      <= busy_d;
    end
  end

  assign STATUS  = status_q;
  assign ENB     = status_q;
  assign READING = reading_q;
  assign RByte   = rbyte_q;

endmodule

// File: tb/tb_draw_cmd_sender.sv
// Directed bench for draw_cmd_sender; packet bytes go through a scoreboard queue.
module tb_draw_cmd_sender;
  localparam int TO = 8;

  logic       ACLK, reset;
  logic       cmd_valid, cmd_ready;
  logic [7:0] cmd_type, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_x2, cmd_y2;
  logic       ENB, STATUS, READING;
  logic [7:0] RByte;
  logic       FinishRead, FinishWrite;
  logic       busy, done, err, proto_err;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  draw_cmd_sender #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
    .ACLK(ACLK), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
    .cmd_x2(cmd_x2), .cmd_y2(cmd_y2),
    .ENB(ENB), .STATUS(STATUS), .READING(READING), .RByte(RByte),
    .FinishRead(FinishRead), .FinishWrite(FinishWrite),
    .busy(busy), .done(done), .err(err), .proto_err(proto_err)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every byte-phase cycle must present the next queued byte.
  always @(negedge ACLK) begin
    if (reset === 1'b0 && READING === 1'b1) begin
      if (exp_q.size() == 0) chk("rbyte_unexpected", 32'd1, 32'd0);
      else chk("rbyte", {24'd0, RByte}, {24'd0, exp_q.pop_front()});
    end
  end

  task automatic wait_ready();
    int t = 0;
    while (cmd_ready !== 1'b1 && t < 50) begin
      @(negedge ACLK);
      t++;
    end
    chk("ready_wait", {31'd0, cmd_ready}, 32'd1);
  endtask

  // Presents one command; returns at the negedge of the cycle after acceptance.
  task automatic drive_cmd(input logic [7:0] t, x0, y0, x1, y1, x2, y2);
    logic [7:0] b[7];
    int n;
    wait_ready();
    b = '{t, x0, y0, x1, y1, x2, y2};
    n = 1 + 2 * int'(t[1:0]);
    if (t[1:0] != 2'd0 && t[7:2] <= 6'd3)
      for (int i = 0; i < n; i++) exp_q.push_back(b[i]);
    cmd_type = t; cmd_x0 = x0; cmd_y0 = y0; cmd_x1 = x1;
    cmd_y1 = y1; cmd_x2 = x2; cmd_y2 = y2;
    cmd_valid = 1'b1;
    @(negedge ACLK);
    cmd_valid = 1'b0;
    // Scramble inputs: packet must come from the captured copy.
    cmd_type = 8'($urandom); cmd_x0 = 8'($urandom); cmd_y0 = 8'($urandom);
    cmd_x1 = 8'($urandom); cmd_y1 = 8'($urandom);
    cmd_x2 = 8'($urandom); cmd_y2 = 8'($urandom);
  endtask

  // Full transaction: fr_idx = byte index carrying FinishRead (-1 none),
  // fw_at = DRAW cycle index carrying FinishWrite (-1 none).
  task automatic do_cmd(input string nm, input logic [7:0] t, x0, y0, x1, y1, x2, y2,
                        input int fr_idx, input int fw_at);
    int n, j;
    logic exp_done, exp_proto;
    n = 1 + 2 * int'(t[1:0]);
    exp_done  = (fw_at >= 0 && fw_at < TO);
    exp_proto = (fr_idx >= 0 && fr_idx < n - 1);
    drive_cmd(t, x0, y0, x1, y1, x2, y2);
    chk({nm, "_proto_clr"}, {31'd0, proto_err}, 32'd0);
    chk({nm, "_busy"}, {busy, cmd_ready}, 32'b10);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge ACLK);
      chk({nm, "_send_st"}, {29'd0, STATUS, ENB, READING}, 32'b111);
      FinishRead = (i == fr_idx);
    end
    @(negedge ACLK);
    FinishRead = 1'b0;
    chk({nm, "_draw_out"}, {21'd0, STATUS, ENB, READING, RByte}, {21'd0, 3'b110, 8'd0});
    chk({nm, "_all_bytes"}, exp_q.size(), 32'd0);
    j = 0;
    FinishWrite = (j == fw_at);
    while (1) begin
      @(negedge ACLK);
      if (STATUS !== 1'b1 || j > 40) break;
      j++;
      FinishWrite = (j == fw_at);
    end
    FinishWrite = 1'b0;
    chk({nm, "_draw_cycles"}, j + 1, exp_done ? fw_at + 1 : TO);
    chk({nm, "_release"}, {27'd0, STATUS, ENB, READING, done, err},
        {27'd0, 3'b000, exp_done, !exp_done});
    chk({nm, "_proto"}, {31'd0, proto_err}, {31'd0, exp_proto});
    chk({nm, "_rel_ready"}, {31'd0, cmd_ready}, 32'd0);
    @(negedge ACLK);
    chk({nm, "_idle"}, {28'd0, done, err, cmd_ready, busy}, 32'b0010);
  endtask

  task automatic do_reject(input string nm, input logic [7:0] t);
    drive_cmd(t, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66);
    chk({nm, "_err"}, {27'd0, err, done, STATUS, cmd_ready, busy}, 32'b10010);
    @(negedge ACLK);
    chk({nm, "_after"}, {28'd0, err, STATUS, READING, cmd_ready}, 32'b0001);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; FinishRead = 1'b0; FinishWrite = 1'b0;
    cmd_type = 8'd0; cmd_x0 = 8'd0; cmd_y0 = 8'd0; cmd_x1 = 8'd0;
    cmd_y1 = 8'd0; cmd_x2 = 8'd0; cmd_y2 = 8'd0;
    repeat (2) @(negedge ACLK);
    chk("reset_outs", {16'd0, STATUS, ENB, READING, RByte, busy, done, err, proto_err},
        {16'd0, 3'b000, 8'd0, 4'b0000});
    chk("reset_ready", {31'd0, cmd_ready}, 32'd1);
    reset = 1'b0;
    @(negedge ACLK);
    chk("idle_ready", {30'd0, cmd_ready, busy}, 32'b10);

    do_cmd("line", 8'h01, 8'h10, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, -1, 5);
    do_cmd("tri", 8'h07, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 6, 0);
    do_reject("rej_p0", 8'h04);
    do_reject("rej_shape", 8'h11);
    do_cmd("timeout", 8'h0E, 8'h40, 8'h50, 8'h08, 8'h00, 8'h00, 8'h00, -1, -1);
    do_cmd("fw_at_expiry", 8'h0A, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h00, 8'h00, -1, TO - 1);
    do_cmd("early_fr", 8'h0A, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'h00, 8'h00, 1, 2);
    do_cmd("after_fr", 8'h01, 8'hC1, 8'hC2, 8'h00, 8'h00, 8'h00, 8'h00, -1, 1);

    // Asynchronous reset while byte index 2 is on the bus.
    drive_cmd(8'h0A, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'h00, 8'h00);
    repeat (2) @(negedge ACLK);
    chk("pre_reset_byte2", {24'd0, RByte}, 32'hD2);
    #1 reset = 1'b1;
    #1;
    chk("async_reset", {21'd0, STATUS, ENB, READING, RByte}, 32'd0);
    exp_q.delete();
    @(negedge ACLK);
    reset = 1'b0;
    @(negedge ACLK);
    chk("post_reset_ready", {30'd0, cmd_ready, busy}, 32'b10);
    do_cmd("post_reset", 8'h05, 8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'h00, 8'h00, -1, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
